// File: rtl/imem_responder.sv
// imem_responder: fetch-side instruction memory with LATENCY wait states, abort/redirect tolerance
// and a byte-strobed loader write port. Define IMEM_STATS_EN to add served/abort event counters.
//
// state | meaning
// IDLE  | no request in flight
// WAIT  | request captured, counting down wait states
// RESP  | data_q/err_q hold the response; valid only if the request still matches addr_q
module imem_responder #(
    parameter int BITSIZE     = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic [BITSIZE-1:0] MEM_addr_i,
    input  logic               MEM_read_i,
    output logic [31:0]        MEM_data_o,
    output logic               MEM_valid_o,
    output logic               MEM_err_o,
    input  logic               wr_en_i,
    input  logic [BITSIZE-1:0] wr_addr_i,
    input  logic [31:0]        wr_data_i,
    input  logic [3:0]         wr_strb_i
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0]        served_cnt_o,
    output logic [31:0]        abort_cnt_o
`endif
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_RELOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [BITSIZE-1:0] addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;

    logic [31:0]        mem_q [DEPTH_WORDS];
    logic [AW-1:0]      rd_idx, wr_idx;
    logic               rd_bad, wr_bad;
    logic [31:0]        rd_word;
    logic               addr_match;
    logic               load_resp;

    // Misaligned, or any address bit above the word-index field is set.
    function automatic logic addr_bad(input logic [BITSIZE-1:0] a);
        logic [BITSIZE-1:0] hi;
        hi = a >> (AW + 2);
        return (a[1:0] != 2'b00) || (hi != '0);
    endfunction

    assign rd_idx     = MEM_addr_i[AW+1:2];
    assign wr_idx     = wr_addr_i[AW+1:2];
    assign rd_bad     = addr_bad(MEM_addr_i);
    assign wr_bad     = addr_bad(wr_addr_i);
    assign rd_word    = rd_bad ? NOP_WORD : mem_q[rd_idx];
    assign addr_match = (MEM_addr_i == addr_q);

    always_ff @(posedge clk) begin
        if (wr_en_i && !wr_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_i[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Array is sampled on the edge entering RESP, so a same-edge write is not seen.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        err_d       = err_q;
        load_resp   = 1'b0;
        MEM_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (MEM_read_i) begin
                    addr_d = MEM_addr_i;
                    if (LATENCY == 1) begin
                        load_resp = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = CNT_RELOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!MEM_read_i) begin
                    state_d = IDLE;
                end else if (!addr_match) begin
                    addr_d = MEM_addr_i;
                    cnt_d  = CNT_RELOAD;
                end else if (cnt_q == 4'd0) begin
                    load_resp = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                MEM_valid_o = MEM_read_i && addr_match;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load_resp) begin
            data_d = rd_word;
            err_d  = rd_bad;
        end
    end

    assign MEM_data_o = data_q;
    assign MEM_err_o  = err_q & MEM_valid_o;

`ifdef IMEM_STATS_EN
    logic [31:0] served_q, abort_q;
    logic        abort_evt;

    // Aborts: drop or redirect while waiting, and a RESP cycle whose request no longer matches.
    assign abort_evt = ((state_q == WAIT) && (!MEM_read_i || !addr_match))
                    || ((state_q == RESP) && !MEM_valid_o);

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            served_q <= 32'd0;
            abort_q  <= 32'd0;
        end else begin
            served_q <= served_q + 32'(MEM_valid_o);
            abort_q  <= abort_q + 32'(abort_evt);
        end
    end

    assign served_cnt_o = served_q;
    assign abort_cnt_o  = abort_q;
`endif

endmodule
